// File: rtl/cordic_shift_pkg.sv
`default_nettype none
// =====================================================================
// cordic_shift_pkg : shared CORDIC datapath defaults and encodings
// Rev 1.0
// =====================================================================
package cordic_shift_pkg;

    localparam int   CORDIC_WIDTH = 32;
    localparam int   CORDIC_SHW   = 5;

    localparam logic DIR_RIGHT    = 1'b0;
    localparam logic DIR_LEFT     = 1'b1;

endpackage : cordic_shift_pkg
`default_nettype wire

// File: rtl/cordic_shift_barrel_shifter.sv
`default_nettype none
// =====================================================================
// barrel_shifter : combinational log-stage shifter, left / logical
//                  right / arithmetic right, stage k shifts by 2^k
// Rev 1.0
// =====================================================================
module barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             left_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] w_stage [0:SHW];
    logic             w_fill;

    // Sign fill only applies to right shifts; left shifts always zero-fill.
    assign w_fill     = arith_i & ~left_i & data_i[WIDTH-1];
    assign w_stage[0] = data_i;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            localparam int SH = 1 << k;
            logic [WIDTH-1:0] w_left;
            logic [WIDTH-1:0] w_right;

            assign w_left  = {w_stage[k][WIDTH-SH-1:0], {SH{1'b0}}};
            assign w_right = {{SH{w_fill}}, w_stage[k][WIDTH-1:SH]};

            assign w_stage[k+1] = !shamt_i[k] ? w_stage[k] :
                                  (left_i ? w_left : w_right);
        end
    endgenerate

    assign data_o = w_stage[SHW];

endmodule : barrel_shifter
`default_nettype wire

// File: rtl/cordic_shift.sv
`default_nettype none
// =====================================================================
// cordic_shift : 1-bit combinational shift plus registered barrel
//                shift path for CORDIC x>>i / y>>i terms
// Rev 1.0
// =====================================================================
module cordic_shift
    import cordic_shift_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH,
    parameter int SHW   = CORDIC_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             rightleft,
    output logic [WIDTH-1:0] shifted,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] w_barrel;
    logic [WIDTH-1:0] result_d;
    logic             valid_d;

    // Single-bit path stays pure wiring, independent of the registered path.
    assign shifted = (rightleft == DIR_RIGHT) ? {1'b0, a[WIDTH-1:1]}
                                              : {a[WIDTH-2:0], 1'b0};

    barrel_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_barrel (
        .data_i  (a),
        .shamt_i (shamt),
        .left_i  (rightleft == DIR_LEFT),
        .arith_i (arith),
        .data_o  (w_barrel)
    );

    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d = w_barrel;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule : cordic_shift
`default_nettype wire

// File: tb/tb_cordic_shift.sv
`default_nettype none
// =====================================================================
// tb_cordic_shift : directed tables, reset/valid sequences and random
//                   stimulus against an arithmetic reference model
// Rev 1.0
// =====================================================================
module tb_cordic_shift;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic        rightleft;
    logic [31:0] shifted;
    logic [4:0]  shamt;
    logic        arith;
    logic        in_valid;
    logic [31:0] result_q;
    logic        valid_q;

    int n_cmp = 0;
    int n_err = 0;

    cordic_shift #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .rightleft (rightleft),
        .shifted   (shifted),
        .shamt     (shamt),
        .arith     (arith),
        .in_valid  (in_valid),
        .result_q  (result_q),
        .valid_q   (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        rl;
        logic [31:0] exp;
    } comb_vec_t;

    typedef struct {
        logic [31:0] a;
        logic        rl;
        logic [4:0]  shamt;
        logic        arith;
        logic [31:0] exp;
    } reg_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: plain shift operators on the whole word.
    function automatic logic [31:0] ref_barrel(input logic [31:0] x, input logic rl,
                                               input logic [4:0] s, input logic ar);
        if (rl) return x << s;
        if (ar) return 32'($signed(x) >>> s);
        return x >> s;
    endfunction

    function automatic logic [31:0] ref_one(input logic [31:0] x, input logic rl);
        return rl ? (x << 1) : (x >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    comb_vec_t   ctab [7];
    reg_vec_t    rtab [7];
    logic [31:0] exp_res;
    logic        exp_val;

    initial begin
        ctab[0] = '{32'hAAAAAAAA, 1'b0, 32'h55555555};
        ctab[1] = '{32'hAAAAAAAA, 1'b1, 32'h55555554};
        ctab[2] = '{32'h00000005, 1'b0, 32'h00000002};
        ctab[3] = '{32'h00000005, 1'b1, 32'h0000000A};
        ctab[4] = '{32'h80000000, 1'b0, 32'h40000000};
        ctab[5] = '{32'h00000001, 1'b1, 32'h00000002};
        ctab[6] = '{32'h80000000, 1'b1, 32'h00000000};

        rtab[0] = '{32'h80000000, 1'b0, 5'd4,  1'b1, 32'hF8000000};
        rtab[1] = '{32'h80000000, 1'b0, 5'd4,  1'b0, 32'h08000000};
        rtab[2] = '{32'h00000003, 1'b1, 5'd31, 1'b0, 32'h80000000};
        rtab[3] = '{32'h00000003, 1'b1, 5'd0,  1'b0, 32'h00000003};
        rtab[4] = '{32'h80000000, 1'b0, 5'd31, 1'b1, 32'hFFFFFFFF};
        rtab[5] = '{32'h00000003, 1'b1, 5'd31, 1'b1, 32'h80000000};
        rtab[6] = '{32'h7FFFFFFF, 1'b0, 5'd30, 1'b1, 32'h00000001};

        rst = 1'b1; a = '0; rightleft = 1'b0; shamt = '0; arith = 1'b0; in_valid = 1'b0;
        tick();
        tick();
        check("reset_result", result_q, 32'h0);
        check("reset_valid", {31'h0, valid_q}, 32'h0);
        rst = 1'b0;

        // Combinational vectors; registered-path inputs scrambled meanwhile.
        for (int i = 0; i < 7; i++) begin
            a = ctab[i].a; rightleft = ctab[i].rl;
            shamt = 5'($urandom); arith = 1'($urandom); in_valid = 1'b0;
            #10;
            check($sformatf("comb_%0d", i), shifted, ctab[i].exp);
        end
        tick();

        for (int i = 0; i < 7; i++) begin
            a = rtab[i].a; rightleft = rtab[i].rl; shamt = rtab[i].shamt;
            arith = rtab[i].arith; in_valid = 1'b1;
            tick();
            check($sformatf("reg_%0d_result", i), result_q, rtab[i].exp);
            check($sformatf("reg_%0d_valid", i), {31'h0, valid_q}, 32'h1);
        end

        // Hold with in_valid low: result stays, valid drops.
        in_valid = 1'b0; a = 32'h12345678; shamt = 5'd3;
        tick();
        check("hold_result", result_q, rtab[6].exp);
        check("hold_valid", {31'h0, valid_q}, 32'h0);

        // Reset wins over a simultaneous valid input.
        rst = 1'b1; in_valid = 1'b1; a = 32'hFFFFFFFF; rightleft = 1'b1; shamt = 5'd1;
        tick();
        check("rst_vs_valid_result", result_q, 32'h0);
        check("rst_vs_valid_valid", {31'h0, valid_q}, 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("post_rst_result", result_q, 32'h0);
        check("post_rst_valid", {31'h0, valid_q}, 32'h0);

        // Random traffic against the model, with occasional resets.
        exp_res = 32'h0;
        exp_val = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = $urandom; rightleft = 1'($urandom); shamt = 5'($urandom);
            arith = 1'($urandom); in_valid = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 31) == 0);
            #1;
            check("rand_shifted", shifted, ref_one(a, rightleft));
            if (rst) begin
                exp_res = 32'h0; exp_val = 1'b0;
            end else if (in_valid) begin
                exp_res = ref_barrel(a, rightleft, shamt, arith); exp_val = 1'b1;
            end else begin
                exp_val = 1'b0;
            end
            tick();
            check("rand_result", result_q, exp_res);
            check("rand_valid", {31'h0, valid_q}, {31'h0, exp_val});
        end
        rst = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cordic_shift
`default_nettype wire
